// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the program memory and the program
// counter. DEPTH-1 is the program-counter wrap point, so both blocks must
// agree on it.
package cpu_pkg;

    localparam int unsigned DATA_WIDTH = 16;   // instruction word width
    localparam int unsigned DEPTH      = 128;  // instruction words in the store
    localparam int unsigned ADDR_WIDTH = 8;    // fetch / program-counter width

    // Word returned for fetches outside the program store.
    localparam logic [DATA_WIDTH-1:0] NOP = '0;

    typedef enum logic {
        IDLE,
        LOAD
    } pm_state_t;

endpackage

// File: rtl/program_ram.sv
// program_ram: single-port synchronous RAM, DEPTH x DATA_WIDTH.
//   clock : rising-edge clock
//   we    : write enable, stores wdata at addr
//   re    : read enable, captures mem[addr] into rdata
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data, holds when re is low
// No reset on the array or the read register: contents are undefined until
// a program has been loaded.
module program_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned AW         = 7
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic                  re,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/program_memory.sv
// program_memory: instruction store that is streamed a program, then answers
// program-counter fetches with a one-cycle registered response.
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   fetch_req         : fetch request (ignored while busy)
//   fetch_address     : requested address
//   instruction       : fetched word (NOP for out-of-range), holds between responses
//   instruction_valid : one-cycle response strobe
//   addr_error        : with instruction_valid when fetch_address >= DEPTH
//   load_start        : start a load at address 0 (idle only)
//   load_valid        : load_data is a beat this cycle
//   load_data         : word to store
//   load_last         : marks the final beat
//   busy              : high while loading
//   load_done         : one-cycle pulse after the final beat
//   word_count        : words written by the last completed load
module program_memory
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int unsigned DEPTH      = cpu_pkg::DEPTH,
    parameter int unsigned ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  instruction_valid,
    output logic                  addr_error,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  busy,
    output logic                  load_done,
    output logic [ADDR_WIDTH-1:0] word_count
);

    localparam int unsigned RAM_AW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_CMP = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [RAM_AW-1:0]     LAST_PTR  = RAM_AW'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] NOP_WORD  = DATA_WIDTH'(NOP);

    pm_state_t state_q, state_d;

    logic [RAM_AW-1:0]     pointer;
    logic [RAM_AW-1:0]     ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  ram_we;
    logic                  ram_re;
    logic                  fetch_accept;
    logic                  in_range;
    logic                  final_beat;
    logic                  nop_sel;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_accept = 1'b0;
        ram_we       = 1'b0;
        final_beat   = 1'b0;
        ram_addr     = fetch_address[RAM_AW-1:0];
        in_range     = ({1'b0, fetch_address} < DEPTH_CMP);
        unique case (state_q)
            IDLE: begin
                fetch_accept = fetch_req;
                if (load_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ram_addr = pointer;
                ram_we   = load_valid;
                // A beat at the last address ends the load even without
                // load_last, so the pointer never wraps.
                final_beat = load_valid && (load_last || (pointer == LAST_PTR));
                if (final_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_re = fetch_accept && in_range;
    assign busy   = (state_q == LOAD);

    // ------------------------------------------------------------------
    // Load pointer, completion and fetch response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pointer           <= '0;
            load_done         <= 1'b0;
            word_count        <= '0;
            instruction_valid <= 1'b0;
            addr_error        <= 1'b0;
            nop_sel           <= 1'b1;
        end else begin
            if ((state_q == IDLE) && load_start) begin
                pointer <= '0;
            end else if (ram_we) begin
                pointer <= pointer + 1'b1;
            end

            load_done <= final_beat;
            if (final_beat) begin
                word_count <= ADDR_WIDTH'(pointer) + ADDR_WIDTH'(1);
            end

            instruction_valid <= fetch_accept;
            addr_error        <= fetch_accept && !in_range;
            if (fetch_accept) begin
                nop_sel <= !in_range;
            end
        end
    end

    // The RAM read register only updates on in-range fetches, so the output
    // holds naturally; nop_sel masks it to NOP after reset and after an
    // out-of-range fetch instead of adding a second data register.
    assign instruction = nop_sel ? NOP_WORD : ram_rdata;

    program_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (RAM_AW)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (load_data),
        .rdata (ram_rdata)
    );

endmodule
